// File: rtl/demux_pkg.sv
// Shared constants and types for the buffered 1-to-N stream demultiplexer.
package demux_pkg;

    localparam int DEMUX_DATA_W_DEF     = 8;
    localparam int DEMUX_N_CH_DEF       = 32;
    localparam int DEMUX_FIFO_DEPTH_DEF = 2;

    localparam int DEMUX_PTR_W_DEF = $clog2(DEMUX_FIFO_DEPTH_DEF);
    localparam int DEMUX_CNT_W_DEF = $clog2(DEMUX_FIFO_DEPTH_DEF) + 1;

    typedef logic [DEMUX_PTR_W_DEF-1:0] fifo_ptr_t;
    typedef logic [DEMUX_CNT_W_DEF-1:0] fifo_cnt_t;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } fifo_occ_e;

endpackage

// File: rtl/demux_ch_fifo.sv
// Per-channel synchronous FIFO with first-word fall-through head output.
// The head holds the last popped word while empty (zero after reset).
module demux_ch_fifo
    import demux_pkg::*;
#(
    parameter int DATA_W = DEMUX_DATA_W_DEF,
    parameter int DEPTH  = DEMUX_FIFO_DEPTH_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [DATA_W-1:0] head_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] hold_q;
    fifo_occ_e         occ;
    logic              push_en;
    logic              pop_en;

    always_comb begin
        occ = OCC_PARTIAL;
        if (count == '0) begin
            occ = OCC_EMPTY;
        end else if (count == CNT_W'(DEPTH)) begin
            occ = OCC_FULL;
        end
    end

    assign full_o  = (occ == OCC_FULL);
    assign empty_o = (occ == OCC_EMPTY);
    assign push_en = push_i & ~full_o;
    assign pop_en  = pop_i & ~empty_o;

    // Storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hold_q <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + 1'b1;
                hold_q <= mem[rd_ptr];
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_o = empty_o ? hold_q : mem[rd_ptr];

endmodule

// File: rtl/demux_stream_1ton.sv
// Buffered 1-to-N stream demux: select decode, ready mux, error pulse and channel FIFOs.
// Optional macro DEMUX_BCAST_EN adds in_bcast_i to push one word into every channel.
module demux_stream_1ton
    import demux_pkg::*;
#(
    parameter int DATA_W     = DEMUX_DATA_W_DEF,
    parameter int N_CH       = DEMUX_N_CH_DEF,
    parameter int FIFO_DEPTH = DEMUX_FIFO_DEPTH_DEF,
    localparam int SEL_W     = $clog2(N_CH)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [DATA_W-1:0]      in_data_i,
    input  logic [SEL_W-1:0]       in_sel_i,
    output logic [N_CH-1:0]        out_valid_o,
    input  logic [N_CH-1:0]        out_ready_i,
    output logic [N_CH*DATA_W-1:0] out_data_o,
`ifdef DEMUX_BCAST_EN
    input  logic                   in_bcast_i,
`endif
    output logic                   err_o
);

    localparam int CMP_W = SEL_W + 1;

    logic [N_CH-1:0] full;
    logic [N_CH-1:0] empty;
    logic [N_CH-1:0] push;
    logic [N_CH-1:0] pop;
    logic            bcast;
    logic            sel_ok;
    logic            sel_full;
    logic            accept;
    logic            err_q;

`ifdef DEMUX_BCAST_EN
    assign bcast = in_bcast_i;
`else
    assign bcast = 1'b0;
`endif

    // Out-of-range selects are always accepted so they can be dropped and flagged.
    always_comb begin
        sel_ok   = ({1'b0, in_sel_i} < CMP_W'(N_CH));
        sel_full = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (in_sel_i == SEL_W'(k)) begin
                sel_full = full[k];
            end
        end
        if (bcast) begin
            in_ready_o = en_i & ~(|full);
        end else begin
            in_ready_o = en_i & (sel_ok ? ~sel_full : 1'b1);
        end
    end

    assign accept = in_valid_i & in_ready_o;

    always_comb begin
        push = '0;
        for (int k = 0; k < N_CH; k++) begin
            push[k] = accept & (bcast | (sel_ok & (in_sel_i == SEL_W'(k))));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept & ~sel_ok & ~bcast;
        end
    end

    assign err_o = err_q;

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_ch
            assign out_valid_o[g] = ~empty[g];
            assign pop[g]         = out_valid_o[g] & out_ready_i[g];

            demux_ch_fifo #(
                .DATA_W (DATA_W),
                .DEPTH  (FIFO_DEPTH)
            ) u_fifo (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .push_i  (push[g]),
                .data_i  (in_data_i),
                .pop_i   (pop[g]),
                .full_o  (full[g]),
                .empty_o (empty[g]),
                .head_o  (out_data_o[g*DATA_W +: DATA_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_demux_stream_1ton.sv
// Directed self-checking bench: 32-channel instance for main behaviour,
// 24-channel instance for out-of-range select drops.
module tb_demux_stream_1ton;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         en;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic [4:0]   in_sel;
    logic [31:0]  out_valid;
    logic [31:0]  out_ready;
    logic [255:0] out_data;
    logic         err;
    logic         bcast;

    logic         en24;
    logic         in_valid24;
    logic         in_ready24;
    logic [7:0]   in_data24;
    logic [4:0]   in_sel24;
    logic [23:0]  out_valid24;
    logic [23:0]  out_ready24;
    logic [191:0] out_data24;
    logic         err24;
    logic         bcast24;

    int errCount   = 0;
    int checkCount = 0;

    demux_stream_1ton #(.DATA_W(8), .N_CH(32), .FIFO_DEPTH(2)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_sel_i    (in_sel),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
`ifdef DEMUX_BCAST_EN
        .in_bcast_i  (bcast),
`endif
        .err_o       (err)
    );

    demux_stream_1ton #(.DATA_W(8), .N_CH(24), .FIFO_DEPTH(2)) dut24 (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en24),
        .in_valid_i  (in_valid24),
        .in_ready_o  (in_ready24),
        .in_data_i   (in_data24),
        .in_sel_i    (in_sel24),
        .out_valid_o (out_valid24),
        .out_ready_i (out_ready24),
        .out_data_o  (out_data24),
`ifdef DEMUX_BCAST_EN
        .in_bcast_i  (bcast24),
`endif
        .err_o       (err24)
    );

    task automatic checkOutput(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checkCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] sel, input logic [7:0] data);
        in_valid = v;
        in_sel   = sel;
        in_data  = data;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] chData(input int k);
        return out_data[k*8 +: 8];
    endfunction

    initial begin
        rst = 1'b1; en = 1'b0; out_ready = '0; bcast = 1'b0;
        applyStimulus(1'b0, 5'd0, 8'h00);
        en24 = 1'b0; in_valid24 = 1'b0; in_sel24 = '0; in_data24 = '0;
        out_ready24 = '0; bcast24 = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        checkOutput("rst_valid", 256'(out_valid), 256'h0);
        checkOutput("rst_data", out_data, 256'h0);
        checkOutput("rst_err", 256'(err), 256'h0);
        checkOutput("rst_rdy_en0", 256'(in_ready), 256'h0);

        // Single word to channel 6
        en = 1'b1;
        applyStimulus(1'b1, 5'd6, 8'hA5);
        #1;
        checkOutput("t1_rdy", 256'(in_ready), 256'h1);
        step();
        applyStimulus(1'b0, 5'd0, 8'h00);
        checkOutput("t1_valid", 256'(out_valid), 256'h0000_0040);
        checkOutput("t1_data", 256'(chData(6)), 256'hA5);
        checkOutput("t1_err", 256'(err), 256'h0);
        out_ready[6] = 1'b1;
        step();
        out_ready = '0;
        checkOutput("t1_drain", 256'(out_valid), 256'h0);

        // Backpressure on channel 14
        applyStimulus(1'b1, 5'd14, 8'h11);
        step();
        applyStimulus(1'b1, 5'd14, 8'h22);
        #1;
        checkOutput("t2_rdy2", 256'(in_ready), 256'h1);
        step();
        applyStimulus(1'b1, 5'd14, 8'h33);
        #1;
        checkOutput("t2_full", 256'(in_ready), 256'h0);
        checkOutput("t2_head11", 256'(chData(14)), 256'h11);
        out_ready[14] = 1'b1;
        #1;
        checkOutput("t2_full_pop", 256'(in_ready), 256'h0);
        step();
        checkOutput("t2_head22", 256'(chData(14)), 256'h22);
        checkOutput("t2_rdy_after", 256'(in_ready), 256'h1);
        step();
        applyStimulus(1'b0, 5'd0, 8'h00);
        checkOutput("t2_head33", 256'(chData(14)), 256'h33);
        checkOutput("t2_valid33", 256'(out_valid), 256'h0000_4000);
        step();
        out_ready = '0;
        checkOutput("t2_empty", 256'(out_valid), 256'h0);

        // Disabled block still drains
        applyStimulus(1'b1, 5'd2, 8'h5A);
        step();
        en = 1'b0;
        applyStimulus(1'b1, 5'd15, 8'hC3);
        #1;
        checkOutput("t3_rdy_en0", 256'(in_ready), 256'h0);
        step();
        checkOutput("t3_no_push", 256'(out_valid), 256'h0000_0004);
        checkOutput("t3_head", 256'(chData(2)), 256'h5A);
        out_ready[2] = 1'b1;
        step();
        out_ready = '0;
        applyStimulus(1'b0, 5'd0, 8'h00);
        checkOutput("t3_drained", 256'(out_valid), 256'h0);
        en = 1'b1;

        // Reset while channel 3 holds two words
        applyStimulus(1'b1, 5'd3, 8'h77);
        step();
        applyStimulus(1'b1, 5'd3, 8'h88);
        step();
        applyStimulus(1'b0, 5'd3, 8'h00);
        checkOutput("t4_pre_valid", 256'(out_valid), 256'h0000_0008);
        checkOutput("t4_pre_head", 256'(chData(3)), 256'h77);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checkOutput("t4_valid", 256'(out_valid), 256'h0);
        checkOutput("t4_data", out_data, 256'h0);
        checkOutput("t4_rdy", 256'(in_ready), 256'h1);
        applyStimulus(1'b1, 5'd3, 8'h99);
        step();
        applyStimulus(1'b0, 5'd0, 8'h00);
        checkOutput("t4_new_head", 256'(chData(3)), 256'h99);
        checkOutput("t4_new_valid", 256'(out_valid), 256'h0000_0008);
        out_ready[3] = 1'b1;
        step();
        out_ready = '0;

        // Out-of-range select on the 24-channel build
        en24 = 1'b1;
        in_valid24 = 1'b1; in_sel24 = 5'd30; in_data24 = 8'hFF;
        #1;
        checkOutput("t5_rdy", 256'(in_ready24), 256'h1);
        step();
        in_sel24 = 5'd31; in_data24 = 8'hEE;
        checkOutput("t5_err1", 256'(err24), 256'h1);
        checkOutput("t5_valid", 256'(out_valid24), 256'h0);
        step();
        in_valid24 = 1'b0;
        checkOutput("t5_err2", 256'(err24), 256'h1);
        step();
        checkOutput("t5_err_clr", 256'(err24), 256'h0);
        checkOutput("t5_valid2", 256'(out_valid24), 256'h0);
        in_valid24 = 1'b1; in_sel24 = 5'd23; in_data24 = 8'h42;
        step();
        in_valid24 = 1'b0;
        checkOutput("t5_ch23_valid", 256'(out_valid24), 256'h80_0000);
        checkOutput("t5_ch23_data", 256'(out_data24[23*8 +: 8]), 256'h42);
        checkOutput("t5_ch23_err", 256'(err24), 256'h0);

`ifdef DEMUX_BCAST_EN
        // Broadcast to every channel
        bcast = 1'b1;
        applyStimulus(1'b1, 5'd9, 8'h3C);
        #1;
        checkOutput("t6_rdy", 256'(in_ready), 256'h1);
        step();
        bcast = 1'b0;
        applyStimulus(1'b0, 5'd0, 8'h00);
        checkOutput("t6_valid", 256'(out_valid), 256'hFFFF_FFFF);
        checkOutput("t6_ch0", 256'(chData(0)), 256'h3C);
        checkOutput("t6_ch31", 256'(chData(31)), 256'h3C);
        checkOutput("t6_err", 256'(err), 256'h0);
        applyStimulus(1'b1, 5'd0, 8'h01);
        step();
        applyStimulus(1'b1, 5'd1, 8'h02);
        bcast = 1'b1;
        #1;
        checkOutput("t6_bcast_full", 256'(in_ready), 256'h0);
        bcast = 1'b0;
        #1;
        checkOutput("t6_uni_ok", 256'(in_ready), 256'h1);
        applyStimulus(1'b0, 5'd0, 8'h00);
`endif

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
